// File: rtl/aes_key_store_pkg.sv
// Shared sizes for the AES round-key store: key width, round count and
// round-index width.
package aes_key_store_pkg;

   localparam int KEY_S     = 128;
   localparam int NR        = 10;
   localparam int RK_ADDR_S = 4;

   localparam logic [RK_ADDR_S-1:0] RK_FIRST = 4'd0;
   localparam logic [RK_ADDR_S-1:0] RK_LAST  = 4'd10;

endpackage

// File: rtl/aes_key_store_ram.sv
// Round-key storage: (NR+1) x KEY_S, one write port and one read port with
// read enable. The array is not reset; only the output register is.
module aes_key_store_ram
   import aes_key_store_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [RK_ADDR_S-1:0] wr_addr,
   input  logic [KEY_S-1:0]     wr_data,
   input  logic                 rd_en,
   input  logic [RK_ADDR_S-1:0] rd_addr,
   output logic [KEY_S-1:0]     rd_data
);

   logic [KEY_S-1:0] mem_r [0:NR];
   logic [KEY_S-1:0] rd_data_r;

   // Write port; addresses beyond the last round are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr <= RK_LAST)) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read; the output holds whenever rd_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= '0;
      end else if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/aes_key_store.sv
// Round-key buffer: captures the expanded schedule and replays it on a
// valid/ready stream. Define AES_KEY_STORE_DECRYPT_EN to build reverse order.
module aes_key_store
   import aes_key_store_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [0:RK_ADDR_S-1] wr_addr,
   input  logic [0:KEY_S-1]     wr_key,
   input  logic                 exp_done,
   input  logic                 rd_start,
   input  logic                 rd_decrypt,
   output logic [0:KEY_S-1]     rd_key,
   output logic [0:RK_ADDR_S-1] rd_round,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic                 rd_last,
   output logic                 keys_valid,
   output logic                 busy,
   output logic                 wr_collision
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e               state_r;
   state_e               state_nx_s;
   logic [RK_ADDR_S-1:0] ptr_r;
   logic [RK_ADDR_S-1:0] ptr_first_s;
   logic [RK_ADDR_S-1:0] ptr_end_s;
   logic [RK_ADDR_S-1:0] ptr_step_s;
   logic [RK_ADDR_S-1:0] rd_round_r;
   logic                 rd_valid_r;
   logic                 rd_last_r;
   logic                 keys_valid_r;
   logic                 busy_r;
   logic                 wr_collision_r;
   logic                 start_s;
   logic                 issue_s;
   logic                 accept_s;
   logic [KEY_S-1:0]     ram_rd_data_s;

`ifdef AES_KEY_STORE_DECRYPT_EN
   logic dec_r;

   // Stream direction, latched with the accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_r <= 1'b0;
      end else if (start_s) begin
         dec_r <= rd_decrypt;
      end
   end

   assign ptr_first_s = rd_decrypt ? RK_LAST : RK_FIRST;
   assign ptr_end_s   = dec_r ? RK_FIRST : RK_LAST;
   assign ptr_step_s  = dec_r ? (ptr_r - 4'd1) : (ptr_r + 4'd1);
`else
   logic unused_decrypt_s;

   assign unused_decrypt_s = rd_decrypt;
   assign ptr_first_s      = RK_FIRST;
   assign ptr_end_s        = RK_LAST;
   assign ptr_step_s       = ptr_r + 4'd1;
`endif

   assign accept_s = rd_valid_r && rd_ready;

   // Next-state and read-issue decode.
   always_comb begin
      state_nx_s = state_r;
      start_s    = 1'b0;
      issue_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd_start && keys_valid_r) begin
               start_s    = 1'b1;
               state_nx_s = ST_ISSUE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            issue_s = !rd_valid_r || rd_ready;
            if (issue_s && (ptr_r == ptr_end_s)) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (accept_s && rd_last_r) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, read pointer, output pipeline and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         ptr_r          <= RK_FIRST;
         rd_round_r     <= RK_FIRST;
         rd_valid_r     <= 1'b0;
         rd_last_r      <= 1'b0;
         keys_valid_r   <= 1'b0;
         busy_r         <= 1'b0;
         wr_collision_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
         if (start_s) begin
            ptr_r <= ptr_first_s;
         end else if (issue_s) begin
            ptr_r <= ptr_step_s;
         end
         // Round index and last flag travel with the one-cycle storage read.
         if (issue_s) begin
            rd_valid_r <= 1'b1;
            rd_round_r <= ptr_r;
            rd_last_r  <= (ptr_r == ptr_end_s);
         end else if (accept_s) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
         end
         if (exp_done) begin
            keys_valid_r <= 1'b1;
         end else if (wr_en && (wr_addr == RK_FIRST)) begin
            keys_valid_r <= 1'b0;
         end
         if (wr_en && busy_r) begin
            wr_collision_r <= 1'b1;
         end
      end
   end

   aes_key_store_ram u_ram (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_key),
      .rd_en   (issue_s),
      .rd_addr (ptr_r),
      .rd_data (ram_rd_data_s)
   );

   assign rd_key       = ram_rd_data_s;
   assign rd_round     = rd_round_r;
   assign rd_valid     = rd_valid_r;
   assign rd_last      = rd_last_r;
   assign keys_valid   = keys_valid_r;
   assign busy         = busy_r;
   assign wr_collision = wr_collision_r;

endmodule

// File: tb/tb_aes_key_store.sv
// Scoreboard bench for aes_key_store using the FIPS-197 A.1 key schedule.
module tb_aes_key_store;

   logic         clk = 1'b0;
   logic         reset;
   logic         wr_en;
   logic [0:3]   wr_addr;
   logic [0:127] wr_key;
   logic         exp_done;
   logic         rd_start;
   logic         rd_decrypt;
   logic [0:127] rd_key;
   logic [0:3]   rd_round;
   logic         rd_valid;
   logic         rd_ready;
   logic         rd_last;
   logic         keys_valid;
   logic         busy;
   logic         wr_collision;

   typedef struct packed {
      logic [127:0] key;
      logic [3:0]   round;
      logic         last;
   } beat_t;

   beat_t        exp_q[$];
   logic [127:0] sched [0:10];
   int           checks = 0;
   int           errors = 0;
   int           beats = 0;
   logic         stall_prev = 1'b0;
   logic [127:0] key_prev = 128'd0;

   always #5 clk = ~clk;

   aes_key_store dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_key       (wr_key),
      .exp_done     (exp_done),
      .rd_start     (rd_start),
      .rd_decrypt   (rd_decrypt),
      .rd_key       (rd_key),
      .rd_round     (rd_round),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_last      (rd_last),
      .keys_valid   (keys_valid),
      .busy         (busy),
      .wr_collision (wr_collision)
   );

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: pops the scoreboard on every accepted beat, checks hold while stalled.
   always @(negedge clk) begin
      if (reset) begin
         if (stall_prev && rd_valid) begin
            chk("stall_hold", rd_key, key_prev);
         end
         stall_prev <= rd_valid && !rd_ready;
         key_prev   <= rd_key;
         if (rd_valid && rd_ready) begin
            beats <= beats + 1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got round %0d expected no beat", rd_round);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_key", rd_key, e.key);
               chk("beat_round", 128'(rd_round), 128'(e.round));
               chk("beat_last", 128'(rd_last), 128'(e.last));
            end
         end
      end else begin
         stall_prev <= 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream(input logic dec);
      logic d;
      d = dec;
`ifndef AES_KEY_STORE_DECRYPT_EN
      d = 1'b0;
`endif
      for (int i = 0; i <= 10; i++) begin
         int r;
         r = d ? (10 - i) : i;
         exp_q.push_back('{key: sched[r], round: 4'(r), last: (i == 10)});
      end
   endtask

   task automatic start_stream(input logic dec);
      rd_decrypt = dec;
      rd_start   = 1'b1;
      push_stream(dec);
      step();
      rd_start   = 1'b0;
      rd_decrypt = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || (exp_q.size() != 0)) && (n < 300)) begin
         step();
         n++;
      end
      chk({name, "_pending"}, 128'(exp_q.size()), 128'd0);
      chk({name, "_busy"}, 128'(busy), 128'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_rd_key"}, rd_key, 128'd0);
      chk({name, "_rd_round"}, 128'(rd_round), 128'd0);
      chk({name, "_rd_valid"}, 128'(rd_valid), 128'd0);
      chk({name, "_rd_last"}, 128'(rd_last), 128'd0);
      chk({name, "_keys_valid"}, 128'(keys_valid), 128'd0);
      chk({name, "_busy"}, 128'(busy), 128'd0);
      chk({name, "_wr_collision"}, 128'(wr_collision), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      sched[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      sched[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      sched[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      sched[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      sched[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      sched[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      sched[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      sched[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      sched[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      sched[9]  = 128'hac7766f319fadc2128d12941575c006e;
      sched[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_key = 128'd0;
      exp_done = 1'b0; rd_start = 1'b0; rd_decrypt = 1'b0; rd_ready = 1'b1;
      repeat (3) step();
      check_reset_outputs("rst");
      reset = 1'b1;
      step();

      // Start with no resident schedule is ignored.
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      repeat (3) step();
      chk("nokeys_busy", 128'(busy), 128'd0);
      chk("nokeys_valid", 128'(rd_valid), 128'd0);

      for (int i = 0; i <= 10; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_key = sched[i];
         step();
      end
      wr_en = 1'b0;
      exp_done = 1'b1; rd_start = 1'b1;
      step();
      exp_done = 1'b0; rd_start = 1'b0;
      chk("expdone_keys_valid", 128'(keys_valid), 128'd1);
      chk("expdone_start_ignored", 128'(busy), 128'd0);
      step();
      chk("expdone_no_valid", 128'(rd_valid), 128'd0);

      // Encrypt stream with cycle-exact timing.
      start_stream(1'b0);
      chk("enc_t1_busy", 128'(busy), 128'd1);
      chk("enc_t1_valid", 128'(rd_valid), 128'd0);
      step();
      chk("enc_t2_valid", 128'(rd_valid), 128'd1);
      repeat (10) step();
      chk("enc_t12_last", 128'(rd_last), 128'd1);
      chk("enc_t12_round", 128'(rd_round), 128'd10);
      step();
      chk("enc_t13_busy", 128'(busy), 128'd0);
      chk("enc_t13_valid", 128'(rd_valid), 128'd0);
      wait_idle("enc");

      start_stream(1'b1);
      wait_idle("dec");

      // Backpressure: ready toggles 1,0,0,1.
      b0 = beats;
      start_stream(1'b0);
      for (int c = 0; (c < 300) && (busy || (exp_q.size() != 0)); c++) begin
         rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
         step();
      end
      rd_ready = 1'b1;
      step();
      chk("bp_beats", 128'(beats - b0), 128'd11);
      wait_idle("bp");

      // Write during a stream; address 11 is dropped so the data stays intact.
      start_stream(1'b0);
      repeat (3) step();
      wr_en = 1'b1; wr_addr = 4'd11; wr_key = {128{1'b1}};
      step();
      wr_en = 1'b0;
      wait_idle("coll");
      chk("coll_flag", 128'(wr_collision), 128'd1);
      chk("coll_keys_valid", 128'(keys_valid), 128'd1);
      repeat (5) step();
      chk("coll_sticky", 128'(wr_collision), 128'd1);

      // keys_valid: set wins over an address-0 write, then a lone write clears it.
      wr_en = 1'b1; wr_addr = 4'd0; wr_key = sched[0]; exp_done = 1'b1;
      step();
      wr_en = 1'b0; exp_done = 1'b0;
      chk("kv_set_wins", 128'(keys_valid), 128'd1);
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      chk("kv_cleared", 128'(keys_valid), 128'd0);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      step();
      chk("kv_start_ignored", 128'(busy), 128'd0);
      exp_done = 1'b1;
      step();
      exp_done = 1'b0;
      chk("kv_restored", 128'(keys_valid), 128'd1);

      // Reset at beat 5 aborts the stream immediately.
      b0 = beats;
      start_stream(1'b0);
      for (int c = 0; (c < 50) && ((beats - b0) < 5); c++) begin
         step();
      end
      chk("abort_reached_beat5", 128'(beats - b0), 128'd5);
      #1 reset = 1'b0;
      #1 check_reset_outputs("abort");
      exp_q.delete();
      step();
      reset = 1'b1;
      step();
      chk("abort_keys_valid", 128'(keys_valid), 128'd0);
      chk("abort_busy", 128'(busy), 128'd0);

      // Storage survives reset.
      exp_done = 1'b1;
      step();
      exp_done = 1'b0;
      start_stream(1'b0);
      wait_idle("survive");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
